// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported, fixed-latency memory between the instruction fetch
// port (IF, read-only) and the data port (D, read/write). One transaction is
// in flight at a time. Each transaction takes MEM_LATENCY+2 cycles:
//   grant cycle (mem_req strobe) -> MEM_LATENCY wait cycles -> one ack cycle.
// On a collision, the port that was not served last wins, so neither port can
// starve the other.
//
// Ports
//   clk, rst               clock (posedge) and synchronous active-high reset
//   if_req/if_addr         fetch request and byte address (held until if_ack)
//   if_rdata/if_ack        fetched word (held until the next IF read) and
//                          one-cycle completion pulse
//   if_stall               if_req && !if_ack, drives the fetch PC hold
//   d_req/d_we/d_addr/
//   d_wdata                data request, write enable, address, write data
//   d_rdata/d_ack          load data (held until the next D read) and
//                          one-cycle completion pulse
//   d_stall                d_req && !d_ack
//   mem_req/mem_we/
//   mem_addr/mem_wdata     memory strobe and command, valid for one cycle
//   mem_rdata              memory read data, valid MEM_LATENCY cycles after
//                          the mem_req cycle
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    output logic              if_stall,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              d_stall,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Down-counter width: must hold MEM_LATENCY-1 (and works for latency 1).
    localparam int CNT_W = $clog2(MEM_LATENCY) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_D  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_next_s;

    logic               owner_r;        // port of the transaction in flight
    logic               last_owner_r;   // port served most recently
    logic               we_r;           // in-flight transaction is a write
    logic [CNT_W-1:0]   cnt_r;          // wait cycles left before read data
    logic [DATA_W-1:0]  if_rdata_r;
    logic [DATA_W-1:0]  d_rdata_r;

    logic               grant_if_s;
    logic               grant_d_s;
    logic               grant_s;
    logic               cnt_zero_s;
    logic               capture_s;

    logic               mem_req_s;
    logic               mem_we_s;
    logic [ADDR_W-1:0]  mem_addr_s;
    logic [DATA_W-1:0]  mem_wdata_s;
    logic               if_ack_s;
    logic               d_ack_s;

    assign grant_s    = grant_if_s | grant_d_s;
    assign cnt_zero_s = (cnt_r == {CNT_W{1'b0}});
    // Read data is on mem_rdata exactly in the last WAIT cycle.
    assign capture_s  = (state_r == ST_WAIT) && cnt_zero_s && !we_r;

    // Arbitration: grants only from IDLE; a collision goes to the port not served last.
    always_comb begin
        grant_if_s = 1'b0;
        grant_d_s  = 1'b0;
        if (state_r == ST_IDLE) begin
            if (if_req && d_req) begin
                if (last_owner_r == OWNER_IF) begin
                    grant_d_s = 1'b1;
                end else begin
                    grant_if_s = 1'b1;
                end
            end else if (if_req) begin
                grant_if_s = 1'b1;
            end else if (d_req) begin
                grant_d_s = 1'b1;
            end else begin
                grant_if_s = 1'b0;
                grant_d_s  = 1'b0;
            end
        end else begin
            grant_if_s = 1'b0;
            grant_d_s  = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_s) begin
                    state_next_s = ST_WAIT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_zero_s) begin
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: memory command from the granted port, ack from the owner in RESP.
    always_comb begin
        mem_req_s   = 1'b0;
        mem_we_s    = 1'b0;
        mem_addr_s  = {ADDR_W{1'b0}};
        mem_wdata_s = {DATA_W{1'b0}};
        if (grant_d_s) begin
            mem_req_s   = 1'b1;
            mem_we_s    = d_we;
            mem_addr_s  = d_addr;
            mem_wdata_s = d_wdata;
        end else if (grant_if_s) begin
            mem_req_s   = 1'b1;
            mem_we_s    = 1'b0;
            mem_addr_s  = if_addr;
            mem_wdata_s = {DATA_W{1'b0}};
        end else begin
            mem_req_s   = 1'b0;
            mem_we_s    = 1'b0;
            mem_addr_s  = {ADDR_W{1'b0}};
            mem_wdata_s = {DATA_W{1'b0}};
        end
        if_ack_s = (state_r == ST_RESP) && (owner_r == OWNER_IF);
        d_ack_s  = (state_r == ST_RESP) && (owner_r == OWNER_D);
    end

    // Transaction bookkeeping: owner, alternation history, write flag, latency counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_r      <= OWNER_IF;
            last_owner_r <= OWNER_IF;
            we_r         <= 1'b0;
            cnt_r        <= {CNT_W{1'b0}};
        end else if (grant_s) begin
            owner_r      <= grant_d_s ? OWNER_D : OWNER_IF;
            last_owner_r <= grant_d_s ? OWNER_D : OWNER_IF;
            we_r         <= grant_d_s & d_we;
            cnt_r        <= CNT_LOAD;
        end else if ((state_r == ST_WAIT) && !cnt_zero_s) begin
            cnt_r        <= cnt_r - CNT_W'(1);
        end else begin
            cnt_r        <= cnt_r;
        end
    end

    // Read-data holding registers; only a completed read on a port updates it.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_rdata_r <= {DATA_W{1'b0}};
            d_rdata_r  <= {DATA_W{1'b0}};
        end else if (capture_s) begin
            if (owner_r == OWNER_IF) begin
                if_rdata_r <= mem_rdata;
            end else begin
                d_rdata_r  <= mem_rdata;
            end
        end else begin
            if_rdata_r <= if_rdata_r;
            d_rdata_r  <= d_rdata_r;
        end
    end

    assign mem_req   = mem_req_s;
    assign mem_we    = mem_we_s;
    assign mem_addr  = mem_addr_s;
    assign mem_wdata = mem_wdata_s;
    assign if_ack    = if_ack_s;
    assign d_ack     = d_ack_s;
    assign if_rdata  = if_rdata_r;
    assign d_rdata   = d_rdata_r;
    // A port stalls from its request until (not including) its ack cycle.
    assign if_stall  = if_req & ~if_ack_s;
    assign d_stall   = d_req & ~d_ack_s;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Cycle-by-cycle vector table for the MEM_LATENCY=2 arbiter (collision after
// reset, lone fetch, write, continuous alternation, request raised in the
// other port's ack cycle), followed by hand-written sequences for reset during
// a WAIT and for a MEM_LATENCY=1 instance. Small memory models return
// address-dependent data exactly MEM_LATENCY cycles after mem_req and junk
// otherwise.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;

    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_ack, if_stall, d_ack, d_stall, mem_req, mem_we;

    logic        l1_if_req, l1_d_req, l1_d_we;
    logic [31:0] l1_if_addr, l1_d_addr, l1_d_wdata;
    logic [31:0] l1_if_rdata, l1_d_rdata, l1_mem_addr, l1_mem_wdata, l1_mem_rdata;
    logic        l1_if_ack, l1_if_stall, l1_d_ack, l1_d_stall, l1_mem_req, l1_mem_we;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(2)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
        .d_ack(d_ack), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .if_req(l1_if_req), .if_addr(l1_if_addr), .if_rdata(l1_if_rdata), .if_ack(l1_if_ack),
        .if_stall(l1_if_stall),
        .d_req(l1_d_req), .d_we(l1_d_we), .d_addr(l1_d_addr), .d_wdata(l1_d_wdata),
        .d_rdata(l1_d_rdata), .d_ack(l1_d_ack), .d_stall(l1_d_stall),
        .mem_req(l1_mem_req), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr),
        .mem_wdata(l1_mem_wdata), .mem_rdata(l1_mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents seen by reads; anything else reads as all ones.
    function automatic logic [31:0] lookup(input logic [31:0] a);
        case (a)
            32'h0000_0040: lookup = 32'h8C22_0004;
            32'h0000_0044: lookup = 32'h2042_0001;
            32'h0000_0100: lookup = 32'h0000_0011;
            32'h0000_0104: lookup = 32'hCAFE_F00D;
            default:       lookup = 32'hFFFF_FFFF;
        endcase
    endfunction

    // Memory models: data valid only in the cycle MEM_LATENCY after mem_req.
    logic        p1_v, p2_v, q1_v;
    logic [31:0] p1_d, p2_d, q1_d;
    always @(posedge clk) begin
        p1_v <= mem_req;
        p1_d <= lookup(mem_addr);
        p2_v <= p1_v;
        p2_d <= p1_d;
        q1_v <= l1_mem_req;
        q1_d <= lookup(l1_mem_addr);
    end
    assign mem_rdata    = p2_v ? p2_d : 32'hBADB_AD00;
    assign l1_mem_rdata = q1_v ? q1_d : 32'hBADB_AD00;

    // Requester protocol: no drop or change of request fields before the ack.
    logic        pi_req, pi_ack, pd_req, pd_ack, pd_we;
    logic [31:0] pi_addr, pd_addr, pd_wdata;
    always @(posedge clk) begin
        if (!rst && pi_req && !pi_ack) begin
            assert (if_req && if_addr == pi_addr)
                else $error("protocol: if_req dropped or if_addr changed before if_ack");
        end
        if (!rst && pd_req && !pd_ack) begin
            assert (d_req && d_addr == pd_addr && d_we == pd_we && d_wdata == pd_wdata)
                else $error("protocol: d_req dropped or D command changed before d_ack");
        end
        pi_req   <= if_req;
        pi_ack   <= if_ack;
        pi_addr  <= if_addr;
        pd_req   <= d_req;
        pd_ack   <= d_ack;
        pd_we    <= d_we;
        pd_addr  <= d_addr;
        pd_wdata <= d_wdata;
    end

    typedef struct {
        logic        rst;
        logic        ifr;
        logic [31:0] ifa;
        logic        dr;
        logic        dwe;
        logic [31:0] da;
        logic [31:0] dwd;
        logic        e_mreq;
        logic        e_mwe;
        logic [31:0] e_maddr;
        logic [31:0] e_mwd;
        logic        e_ifack;
        logic        e_dack;
        logic        e_ifst;
        logic        e_dst;
        logic [31:0] e_ifrd;
        logic [31:0] e_drd;
    } vec_t;

    vec_t vecs[64];
    int   nvec = 0;

    task automatic add(input int n, input logic r, input logic ifr, input logic [31:0] ifa,
                       input logic dr, input logic dwe, input logic [31:0] da, input logic [31:0] dwd,
                       input logic mreq, input logic mwe, input logic [31:0] maddr, input logic [31:0] mwd,
                       input logic ifack, input logic dack, input logic ifst, input logic dst,
                       input logic [31:0] ifrd, input logic [31:0] drd);
        for (int k = 0; k < n; k++) begin
            vecs[nvec].rst     = r;
            vecs[nvec].ifr     = ifr;
            vecs[nvec].ifa     = ifa;
            vecs[nvec].dr      = dr;
            vecs[nvec].dwe     = dwe;
            vecs[nvec].da      = da;
            vecs[nvec].dwd     = dwd;
            vecs[nvec].e_mreq  = mreq;
            vecs[nvec].e_mwe   = mwe;
            vecs[nvec].e_maddr = maddr;
            vecs[nvec].e_mwd   = mwd;
            vecs[nvec].e_ifack = ifack;
            vecs[nvec].e_dack  = dack;
            vecs[nvec].e_ifst  = ifst;
            vecs[nvec].e_dst   = dst;
            vecs[nvec].e_ifrd  = ifrd;
            vecs[nvec].e_drd   = drd;
            nvec++;
        end
    endtask

    task automatic cmp32(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %08h expected %08h", name, idx, act, exp);
        end
    endtask

    task automatic cmp1(input string name, input int idx, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0b expected %0b", name, idx, act, exp);
        end
    endtask

    // Advance to just after the next active edge, where inputs are driven.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        if_req = 1'b0; if_addr = 32'h0; d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
        l1_if_req = 1'b0; l1_if_addr = 32'h0; l1_d_req = 1'b0; l1_d_we = 1'b0;
        l1_d_addr = 32'h0; l1_d_wdata = 32'h0;

        //  n  rst   ifr   ifa          dr    dwe   da           dwd            mreq  mwe   maddr        mwd            ifack dack  ifst  dst   if_rdata       d_rdata
        // reset, then idle
        add(1, 1'b1, 1'b0, 32'h0,       1'b0, 1'b0, 32'h0,       32'h0,         1'b0, 1'b0, 32'h0,       32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0);
        add(1, 1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 32'h0,       32'h0,         1'b0, 1'b0, 32'h0,       32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0);
        // collision right after reset: D first, then IF
        add(1, 1'b0, 1'b1, 32'h44,      1'b1, 1'b0, 32'h100,     32'h0,         1'b1, 1'b0, 32'h100,     32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 32'h0,         32'h0);
        add(2, 1'b0, 1'b1, 32'h44,      1'b1, 1'b0, 32'h100,     32'h0,         1'b0, 1'b0, 32'h0,       32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 32'h0,         32'h0);
        add(1, 1'b0, 1'b1, 32'h44,      1'b1, 1'b0, 32'h100,     32'h0,         1'b0, 1'b0, 32'h0,       32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         32'h11);
        add(1, 1'b0, 1'b1, 32'h44,      1'b0, 1'b0, 32'h0,       32'h0,         1'b1, 1'b0, 32'h44,      32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         32'h11);
        add(2, 1'b0, 1'b1, 32'h44,      1'b0, 1'b0, 32'h0,       32'h0,         1'b0, 1'b0, 32'h0,       32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         32'h11);
        add(1, 1'b0, 1'b1, 32'h44,      1'b0, 1'b0, 32'h0,       32'h0,         1'b0, 1'b0, 32'h0,       32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 32'h20420001,  32'h11);
        // D write: d_rdata keeps 0x11; IF raises req in the D ack cycle
        add(1, 1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 32'h200,     32'hDEADBEEF,  1'b1, 1'b1, 32'h200,     32'hDEADBEEF,  1'b0, 1'b0, 1'b0, 1'b1, 32'h20420001,  32'h11);
        add(2, 1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 32'h200,     32'hDEADBEEF,  1'b0, 1'b0, 32'h0,       32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 32'h20420001,  32'h11);
        add(1, 1'b0, 1'b1, 32'h40,      1'b1, 1'b1, 32'h200,     32'hDEADBEEF,  1'b0, 1'b0, 32'h0,       32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 32'h20420001,  32'h11);
        // lone fetch of 0x40
        add(1, 1'b0, 1'b1, 32'h40,      1'b0, 1'b0, 32'h0,       32'h0,         1'b1, 1'b0, 32'h40,      32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 32'h20420001,  32'h11);
        add(2, 1'b0, 1'b1, 32'h40,      1'b0, 1'b0, 32'h0,       32'h0,         1'b0, 1'b0, 32'h0,       32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 32'h20420001,  32'h11);
        add(1, 1'b0, 1'b1, 32'h40,      1'b0, 1'b0, 32'h0,       32'h0,         1'b0, 1'b0, 32'h0,       32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 32'h8C220004,  32'h11);
        // both held: D(0x104), IF(0x44), D(0x100), IF(0x40)
        add(1, 1'b0, 1'b1, 32'h44,      1'b1, 1'b0, 32'h104,     32'h0,         1'b1, 1'b0, 32'h104,     32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 32'h8C220004,  32'h11);
        add(2, 1'b0, 1'b1, 32'h44,      1'b1, 1'b0, 32'h104,     32'h0,         1'b0, 1'b0, 32'h0,       32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 32'h8C220004,  32'h11);
        add(1, 1'b0, 1'b1, 32'h44,      1'b1, 1'b0, 32'h104,     32'h0,         1'b0, 1'b0, 32'h0,       32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 32'h8C220004,  32'hCAFEF00D);
        add(1, 1'b0, 1'b1, 32'h44,      1'b1, 1'b0, 32'h100,     32'h0,         1'b1, 1'b0, 32'h44,      32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 32'h8C220004,  32'hCAFEF00D);
        add(2, 1'b0, 1'b1, 32'h44,      1'b1, 1'b0, 32'h100,     32'h0,         1'b0, 1'b0, 32'h0,       32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 32'h8C220004,  32'hCAFEF00D);
        add(1, 1'b0, 1'b1, 32'h44,      1'b1, 1'b0, 32'h100,     32'h0,         1'b0, 1'b0, 32'h0,       32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 32'h20420001,  32'hCAFEF00D);
        add(1, 1'b0, 1'b1, 32'h40,      1'b1, 1'b0, 32'h100,     32'h0,         1'b1, 1'b0, 32'h100,     32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 32'h20420001,  32'hCAFEF00D);
        add(2, 1'b0, 1'b1, 32'h40,      1'b1, 1'b0, 32'h100,     32'h0,         1'b0, 1'b0, 32'h0,       32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 32'h20420001,  32'hCAFEF00D);
        add(1, 1'b0, 1'b1, 32'h40,      1'b1, 1'b0, 32'h100,     32'h0,         1'b0, 1'b0, 32'h0,       32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 32'h20420001,  32'h11);
        add(1, 1'b0, 1'b1, 32'h40,      1'b0, 1'b0, 32'h0,       32'h0,         1'b1, 1'b0, 32'h40,      32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 32'h20420001,  32'h11);
        add(2, 1'b0, 1'b1, 32'h40,      1'b0, 1'b0, 32'h0,       32'h0,         1'b0, 1'b0, 32'h0,       32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 32'h20420001,  32'h11);
        add(1, 1'b0, 1'b1, 32'h40,      1'b0, 1'b0, 32'h0,       32'h0,         1'b0, 1'b0, 32'h0,       32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 32'h8C220004,  32'h11);
        add(1, 1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 32'h0,       32'h0,         1'b0, 1'b0, 32'h0,       32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h8C220004,  32'h11);

        for (int i = 0; i < nvec; i++) begin
            cyc();
            rst = vecs[i].rst; if_req = vecs[i].ifr; if_addr = vecs[i].ifa;
            d_req = vecs[i].dr; d_we = vecs[i].dwe; d_addr = vecs[i].da; d_wdata = vecs[i].dwd;
            @(negedge clk);
            if (!vecs[i].rst) begin
                cmp1("mem_req", i, mem_req, vecs[i].e_mreq);
                cmp1("mem_we", i, mem_we, vecs[i].e_mwe);
                if (vecs[i].e_mreq) begin
                    cmp32("mem_addr", i, mem_addr, vecs[i].e_maddr);
                    cmp32("mem_wdata", i, mem_wdata, vecs[i].e_mwd);
                end
                cmp1("if_ack", i, if_ack, vecs[i].e_ifack);
                cmp1("d_ack", i, d_ack, vecs[i].e_dack);
                cmp1("if_stall", i, if_stall, vecs[i].e_ifst);
                cmp1("d_stall", i, d_stall, vecs[i].e_dst);
                cmp32("if_rdata", i, if_rdata, vecs[i].e_ifrd);
                cmp32("d_rdata", i, d_rdata, vecs[i].e_drd);
            end
        end

        // Reset during the WAIT of an IF read: abandoned, late data ignored.
        cyc(); if_req = 1'b1; if_addr = 32'h44;
        @(negedge clk);
        cmp1("rst_seq grant", 100, mem_req, 1'b1);
        cmp32("rst_seq addr", 100, mem_addr, 32'h44);
        cyc(); rst = 1'b1; if_req = 1'b0;
        cyc(); rst = 1'b0;
        @(negedge clk);
        cmp1("rst_seq mem_req", 102, mem_req, 1'b0);
        cmp1("rst_seq mem_we", 102, mem_we, 1'b0);
        cmp1("rst_seq if_ack", 102, if_ack, 1'b0);
        cmp1("rst_seq d_ack", 102, d_ack, 1'b0);
        cmp1("rst_seq if_stall", 102, if_stall, 1'b0);
        cmp32("rst_seq if_rdata", 102, if_rdata, 32'h0);
        cmp32("rst_seq d_rdata", 102, d_rdata, 32'h0);
        cyc(); if_req = 1'b1; if_addr = 32'h40;
        @(negedge clk);
        cmp1("rst_seq regrant", 103, mem_req, 1'b1);
        cmp32("rst_seq regrant addr", 103, mem_addr, 32'h40);
        cmp32("rst_seq late data", 103, if_rdata, 32'h0);
        cmp1("rst_seq no ack", 103, if_ack, 1'b0);
        for (int w = 0; w < 2; w++) begin
            cyc();
            @(negedge clk);
            cmp1("rst_seq wait ack", 104 + w, if_ack, 1'b0);
            cmp1("rst_seq wait stall", 104 + w, if_stall, 1'b1);
        end
        cyc();
        @(negedge clk);
        cmp1("rst_seq ack", 106, if_ack, 1'b1);
        cmp32("rst_seq if_rdata", 106, if_rdata, 32'h8C220004);
        cyc(); if_req = 1'b0;

        // MEM_LATENCY=1 instance: D read, then back-to-back second read.
        cyc(); l1_d_req = 1'b1; l1_d_addr = 32'h104;
        @(negedge clk);
        cmp1("l1 grant", 200, l1_mem_req, 1'b1);
        cmp32("l1 addr", 200, l1_mem_addr, 32'h104);
        cmp1("l1 we", 200, l1_mem_we, 1'b0);
        cmp32("l1 wdata", 200, l1_mem_wdata, 32'h0);
        cmp1("l1 stall", 200, l1_d_stall, 1'b1);
        cyc();
        @(negedge clk);
        cmp1("l1 wait req", 201, l1_mem_req, 1'b0);
        cmp1("l1 wait ack", 201, l1_d_ack, 1'b0);
        cmp1("l1 wait stall", 201, l1_d_stall, 1'b1);
        cyc();
        @(negedge clk);
        cmp1("l1 ack", 202, l1_d_ack, 1'b1);
        cmp1("l1 ack stall", 202, l1_d_stall, 1'b0);
        cmp32("l1 d_rdata", 202, l1_d_rdata, 32'hCAFEF00D);
        cmp1("l1 if_ack", 202, l1_if_ack, 1'b0);
        cmp1("l1 if_stall", 202, l1_if_stall, 1'b0);
        cmp32("l1 if_rdata", 202, l1_if_rdata, 32'h0);
        cyc(); l1_d_addr = 32'h100;
        @(negedge clk);
        cmp1("l1 next grant", 203, l1_mem_req, 1'b1);
        cmp32("l1 next addr", 203, l1_mem_addr, 32'h100);
        cyc();
        cyc();
        @(negedge clk);
        cmp1("l1 ack2", 205, l1_d_ack, 1'b1);
        cmp32("l1 d_rdata2", 205, l1_d_rdata, 32'h11);
        cyc(); l1_d_req = 1'b0;
        @(negedge clk);
        cmp1("l1 idle", 206, l1_mem_req, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, fixed-latency memory between two requesters: the instruction fetch stage (IF, read-only) and the data memory stage (D, read/write).
- Sequences each transaction and returns read data with a one-cycle ack.
- Generates per-port stall outputs. if_stall drives the fetch stage's `hazard` (PC hold) input.
- Sits between the pipeline front/back ends and the unified memory.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LATENCY, 2, cycles from the mem_req cycle to valid mem_rdata. Legal values are 1 or more.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- if_req  in  1  fetch read request; held high until if_ack.
- if_addr  in  ADDR_W  fetch byte address; stable while if_req is high.
- if_rdata  out  DATA_W  fetched instruction.
- if_ack  out  1  one-cycle completion pulse for IF.
- if_stall  out  1  if_req and not if_ack.
- d_req  in  1  data request; held high until d_ack.
- d_we  in  1  1 = write, 0 = read; stable while d_req is high.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  DATA_W  write data.
- d_rdata  out  DATA_W  load data.
- d_ack  out  1  one-cycle completion pulse for D.
- d_stall  out  1  d_req and not d_ack.
- mem_req  out  1  memory access strobe, one cycle per transaction.
- mem_we  out  1  memory write enable, valid with mem_req.
- mem_addr  out  ADDR_W  memory address, valid with mem_req.
- mem_wdata  out  DATA_W  memory write data, valid with mem_req.
- mem_rdata  in  DATA_W  memory read data, valid exactly MEM_LATENCY cycles after mem_req.

Behaviour:

State machine: IDLE, WAIT, RESP.

IDLE:
- If no request is pending: stay in IDLE, mem_req=0.
- If exactly one port requests: grant it.
- If both request: grant the port that is NOT last_owner (alternation, no starvation).
- On grant, in the same cycle (combinational from the state and the registered owner select):
  - mem_req=1.
  - mem_addr, mem_wdata and mem_we come from the granted port. mem_we=0 for IF.
  - owner<=granted, last_owner<=granted, cnt<=MEM_LATENCY-1.
  - Next state WAIT.

WAIT:
- mem_req=0.
- While cnt is not 0: cnt decrements by 1.
- When cnt==0: mem_rdata is valid this cycle.
  - Read: capture into owner's rdata register.
  - Write: d_rdata is unchanged.
  - Next state RESP.
- cnt width is clog2(MEM_LATENCY)+1.

RESP:
- Assert owner's ack for exactly one cycle.
- No grant is made in this cycle; the acked port's req is still high.
- Next state IDLE.

Timing:
- Grant in cycle T gives ack in cycle T+MEM_LATENCY+1.
- The earliest next grant is T+MEM_LATENCY+2.
- Each transaction therefore occupies MEM_LATENCY+2 cycles.

Stalls:
- if_stall and d_stall are combinational: req and not ack.
- Stall is high during the grant cycle and the WAIT cycles.
- Stall is low in the ack cycle.

Output holding:
- if_rdata and d_rdata hold their last captured value until the next read completes on the same port.

Reset (rst high at an edge):
- Next cycle: state=IDLE, cnt=0, owner=IF, last_owner=IF (so D wins the first collision).
- if_rdata=0, d_rdata=0, acks=0, mem_req=0, mem_we=0.
- Any in-flight transaction is abandoned with no ack. A late mem_rdata is ignored.
- Requesters re-issue after reset.

Protocol assumptions (bench must assert):
- A requester never drops req, or changes addr/we/wdata, before its ack.
- A requester raising req in the ack cycle of the other port is served normally.

Test Plan:
1. MEM_LATENCY=2, lone if_req with if_addr=0x40 at T; memory returns 0x8C220004 at T+2 -> mem_req=1 and mem_addr=0x40 only at T; if_ack pulse at T+3 with if_rdata=0x8C220004; if_stall=1 for T..T+2, 0 at T+3.
2. First request after reset, if_req and d_req both rise at T (d_we=0, d_addr=0x100) -> D granted at T, d_ack at T+3; IF granted at T+4 with mem_addr=if_addr, if_ack at T+7.
3. Both ports hold req continuously for 4 transactions -> grants alternate D, IF, D, IF at T, T+4, T+8, T+12; no port is granted twice in a row.
4. D write with d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF, prior d_rdata=0x11 -> mem_req=mem_we=1 for one cycle at T with matching addr/data; d_ack at T+3; d_rdata stays 0x11.
5. rst asserted at T+1 during a WAIT for an IF read -> no if_ack; state IDLE and all outputs 0 after the reset edge; the re-issued if_req completes normally after MEM_LATENCY+1 cycles.
6. MEM_LATENCY=1 with a single D read at T -> mem_rdata captured at T+1, d_ack at T+2, next grant possible at T+3.
